// File: rtl/fc_feeder.sv
// Upstream driver for fc_layer: loads weight rows, then streams input vectors
// diagonally skewed across lanes with start/valid framing, one batch at a time.
module fc_feeder #(
    parameter int unsigned BitSize     = 8,
    parameter int unsigned M_W_BitSize = 8,
    parameter int unsigned NumOfInputs = 2,
    parameter int unsigned NumOfNerves = 3,
    parameter int unsigned Height      = 2
) (
    input  logic                              clk,
    input  logic                              res,
    input  logic                              load_start,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [NumOfNerves*M_W_BitSize-1:0] w_data,
    input  logic                              v_valid,
    output logic                              v_ready,
    input  logic [NumOfInputs*BitSize-1:0]    v_data,
    input  logic                              fc_done,
    output logic [NumOfNerves*M_W_BitSize-1:0] out_weights,
    output logic                              out_en_l_b,
    output logic [NumOfInputs*BitSize-1:0]    out_data,
    output logic                              out_valid,
    output logic                              out_start,
    output logic                              busy,
    output logic                              batch_done
);

    localparam int unsigned WeightW   = NumOfNerves * M_W_BitSize;
    localparam int unsigned RowCntW   = (NumOfInputs > 1) ? $clog2(NumOfInputs) : 1;
    localparam int unsigned VecCntW   = (Height > 1) ? $clog2(Height) : 1;
    localparam int unsigned DrainLast = (NumOfInputs > 1) ? NumOfInputs - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_WAIT_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [RowCntW-1:0]   row_cnt_q, row_cnt_d;
    logic [VecCntW-1:0]   vec_cnt_q, vec_cnt_d;
    logic [RowCntW-1:0]   drn_cnt_q, drn_cnt_d;
    logic [WeightW-1:0]   out_weights_q, out_weights_d;
    logic                 en_l_b_q, en_l_b_d;
    logic [NumOfInputs-1:0] hist_q, hist_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_start_q, out_start_d;
    logic                 w_ready_q, w_ready_d;
    logic                 v_ready_q, v_ready_d;
    logic                 busy_q, busy_d;
    logic                 batch_done_q, batch_done_d;
    logic                 w_hs;
    logic                 v_hs;

    assign w_hs = w_valid & w_ready_q;
    assign v_hs = v_valid & v_ready_q;

    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        vec_cnt_d     = vec_cnt_q;
        drn_cnt_d     = drn_cnt_q;
        out_weights_d = out_weights_q;
        en_l_b_d      = 1'b0;
        batch_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d   = S_LOAD;
                    row_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (w_hs) begin
                    out_weights_d = w_data;
                    en_l_b_d      = 1'b1;
                    if (row_cnt_q == RowCntW'(NumOfInputs - 1)) begin
                        state_d   = S_STREAM;
                        vec_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + RowCntW'(1);
                    end
                end
            end
            S_STREAM: begin
                // an accepted vector takes priority over a reload request
                if (v_hs) begin
                    if (vec_cnt_q == VecCntW'(Height - 1)) begin
                        state_d   = (NumOfInputs > 1) ? S_DRAIN : S_WAIT_DONE;
                        drn_cnt_d = '0;
                    end else begin
                        vec_cnt_d = vec_cnt_q + VecCntW'(1);
                    end
                end else if (load_start && (vec_cnt_q == '0)) begin
                    state_d   = S_LOAD;
                    row_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (drn_cnt_q == RowCntW'(DrainLast)) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    drn_cnt_d = drn_cnt_q + RowCntW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (fc_done) begin
                    batch_done_d = 1'b1;
                    state_d      = S_STREAM;
                    vec_cnt_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // bit j set: a vector was accepted j+1 cycles ago, so lane j holds data
        hist_d      = (hist_q << 1) | NumOfInputs'(v_hs);
        out_valid_d = |hist_d;
        out_start_d = hist_d[0];
        w_ready_d   = (state_d == S_LOAD);
        v_ready_d   = (state_d == S_STREAM);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q       <= S_IDLE;
            row_cnt_q     <= '0;
            vec_cnt_q     <= '0;
            drn_cnt_q     <= '0;
            out_weights_q <= '0;
            en_l_b_q      <= 1'b0;
            hist_q        <= '0;
            out_valid_q   <= 1'b0;
            out_start_q   <= 1'b0;
            w_ready_q     <= 1'b0;
            v_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
            batch_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            vec_cnt_q     <= vec_cnt_d;
            drn_cnt_q     <= drn_cnt_d;
            out_weights_q <= out_weights_d;
            en_l_b_q      <= en_l_b_d;
            hist_q        <= hist_d;
            out_valid_q   <= out_valid_d;
            out_start_q   <= out_start_d;
            w_ready_q     <= w_ready_d;
            v_ready_q     <= v_ready_d;
            busy_q        <= busy_d;
            batch_done_q  <= batch_done_d;
        end
    end

    // lane k: (k+1)-stage chain, last stage drives the output directly
    for (genvar k = 0; k < NumOfInputs; k++) begin : g_lane
        logic [BitSize-1:0] dat_q [0:k];
        logic [BitSize-1:0] dat_d [0:k];

        always_comb begin
            dat_d[0] = v_hs ? v_data[k*BitSize +: BitSize] : '0;
            for (int j = 1; j <= k; j++) begin
                dat_d[j] = dat_q[j-1];
            end
        end

        always_ff @(posedge clk or posedge res) begin
            if (res) begin
                for (int j = 0; j <= k; j++) begin
                    dat_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j <= k; j++) begin
                    dat_q[j] <= dat_d[j];
                end
            end
        end

        assign out_data[k*BitSize +: BitSize] = dat_q[k];
    end

    assign out_weights = out_weights_q;
    assign out_en_l_b  = en_l_b_q;
    assign out_valid   = out_valid_q;
    assign out_start   = out_start_q;
    assign w_ready     = w_ready_q;
    assign v_ready     = v_ready_q;
    assign busy        = busy_q;
    assign batch_done  = batch_done_q;

endmodule

// File: tb/tb_fc_feeder.sv
// Scoreboard bench for fc_feeder: stimulus queues hand-computed weight rows and
// lane frames; a negedge monitor pops and compares whenever the DUT presents them.
module tb_fc_feeder;

    localparam int unsigned BS = 8;
    localparam int unsigned WB = 8;
    localparam int unsigned NI = 2;
    localparam int unsigned NN = 3;
    localparam int unsigned HT = 2;

    logic              clk = 1'b0;
    logic              res = 1'b0;
    logic              load_start = 1'b0;
    logic              w_valid = 1'b0;
    logic              w_ready;
    logic [NN*WB-1:0]  w_data = '0;
    logic              v_valid = 1'b0;
    logic              v_ready;
    logic [NI*BS-1:0]  v_data = '0;
    logic              fc_done = 1'b0;
    logic [NN*WB-1:0]  out_weights;
    logic              out_en_l_b;
    logic [NI*BS-1:0]  out_data;
    logic              out_valid;
    logic              out_start;
    logic              busy;
    logic              batch_done;

    fc_feeder #(
        .BitSize(BS), .M_W_BitSize(WB), .NumOfInputs(NI), .NumOfNerves(NN), .Height(HT)
    ) dut (
        .clk(clk), .res(res), .load_start(load_start),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .v_valid(v_valid), .v_ready(v_ready), .v_data(v_data),
        .fc_done(fc_done), .out_weights(out_weights), .out_en_l_b(out_en_l_b),
        .out_data(out_data), .out_valid(out_valid), .out_start(out_start),
        .busy(busy), .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int bd_seen = 0;
    int bd_exp  = 0;
    logic [NN*WB-1:0] wq [$];
    logic [NI*BS:0]   fq [$];   // {out_start, out_data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops expected rows/frames when the DUT presents them
    always @(negedge clk) begin
        if (!res) begin
            if (out_en_l_b) begin
                if (wq.size() == 0) check("en_l_b with no row pending", 32'(out_en_l_b), 32'd0);
                else                check("out_weights", 32'(out_weights), 32'(wq.pop_front()));
            end
            if (out_valid) begin
                if (fq.size() == 0) check("out_valid with no frame pending", 32'(out_valid), 32'd0);
                else                check("lane frame", 32'({out_start, out_data}), 32'(fq.pop_front()));
            end else begin
                check("idle lanes zero", 32'({out_start, out_data}), 32'd0);
            end
            if (batch_done) bd_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_weights"}, 32'(out_weights), 32'd0);
        check({tag, " out_data"},    32'(out_data),    32'd0);
        check({tag, " out_en_l_b"},  32'(out_en_l_b),  32'd0);
        check({tag, " out_valid"},   32'(out_valid),   32'd0);
        check({tag, " out_start"},   32'(out_start),   32'd0);
        check({tag, " w_ready"},     32'(w_ready),     32'd0);
        check({tag, " v_ready"},     32'(v_ready),     32'd0);
        check({tag, " busy"},        32'(busy),        32'd0);
        check({tag, " batch_done"},  32'(batch_done),  32'd0);
    endtask

    task automatic wait_vready();
        int n = 0;
        while (!v_ready && n < 20) begin
            tick();
            n++;
        end
        check("v_ready before send", 32'(v_ready), 32'd1);
    endtask

    // two vectors with `gap` idle cycles between them
    task automatic send_pair(input logic [NI*BS-1:0] a, input logic [NI*BS-1:0] b, input int gap);
        wait_vready();
        v_valid = 1'b1;
        v_data  = a;
        tick();
        if (gap > 0) begin
            v_valid = 1'b0;
            repeat (gap) tick();
            wait_vready();
            v_valid = 1'b1;
        end
        v_data = b;
        tick();
        v_valid = 1'b0;
        v_data  = '0;
        check("v_ready after last handshake", 32'(v_ready), 32'd0);
    endtask

    task automatic finish_batch(input int hold, input logic with_load);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("v_ready while waiting", 32'(v_ready), 32'd0);
            check("busy while waiting",    32'(busy),    32'd1);
        end
        fc_done    = 1'b1;
        load_start = with_load;
        bd_exp++;
        tick();
        fc_done    = 1'b0;
        load_start = 1'b0;
        check("batch_done pulse",        32'(batch_done), 32'd1);
        check("v_ready after fc_done",   32'(v_ready),    32'd1);
        check("w_ready after fc_done",   32'(w_ready),    32'd0);
        tick();
        check("batch_done one cycle",    32'(batch_done), 32'd0);
        check("w_ready stays low",       32'(w_ready),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 res = 1'b1;
        #2 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 res = 1'b0;
        tick();

        // reset in the middle of a weight load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        w_valid    = 1'b1;
        w_data     = 24'h0A0B0C;
        tick();
        w_valid = 1'b0;
        res     = 1'b1;
        #1 check_all_zero("mid-load reset");
        @(posedge clk);
        #2 res = 1'b0;
        tick();

        // full weight load, rows back to back
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        w_valid    = 1'b1;
        w_data     = 24'h010001;
        wq.push_back(24'h010001);
        tick();
        check("en_l_b row0", 32'(out_en_l_b), 32'd1);
        check("weights row0", 32'(out_weights), 32'h010001);
        w_data = 24'h010101;
        wq.push_back(24'h010101);
        tick();
        w_valid = 1'b0;
        check("en_l_b row1", 32'(out_en_l_b), 32'd1);
        check("weights row1", 32'(out_weights), 32'h010101);
        tick();
        check("en_l_b after load", 32'(out_en_l_b), 32'd0);
        check("weights held", 32'(out_weights), 32'h010101);
        check("v_ready in stream", 32'(v_ready), 32'd1);

        // vectors [7,6],[7,6] two cycles apart
        fq.push_back(17'h10007); fq.push_back(17'h00600);
        fq.push_back(17'h10007); fq.push_back(17'h00600);
        send_pair(16'h0607, 16'h0607, 1);
        finish_batch(3, 1'b0);
        check("frames drained A", 32'(fq.size()), 32'd0);

        // back to back, then fc_done held off for 10 cycles
        fq.push_back(17'h10007); fq.push_back(17'h10607); fq.push_back(17'h00600);
        send_pair(16'h0607, 16'h0607, 0);
        finish_batch(10, 1'b0);
        check("frames drained B", 32'(fq.size()), 32'd0);

        // 3-cycle gap, old weights kept
        fq.push_back(17'h10007); fq.push_back(17'h00600);
        fq.push_back(17'h10007); fq.push_back(17'h00600);
        send_pair(16'h0607, 16'h0607, 3);
        finish_batch(3, 1'b0);
        check("frames drained C", 32'(fq.size()), 32'd0);

        // load_start coincident with fc_done is dropped
        fq.push_back(17'h10007); fq.push_back(17'h10607); fq.push_back(17'h00600);
        send_pair(16'h0607, 16'h0607, 0);
        finish_batch(3, 1'b1);

        repeat (4) tick();
        check("frame queue empty", 32'(fq.size()), 32'd0);
        check("weight queue empty", 32'(wq.size()), 32'd0);
        check("batch_done count", 32'(bd_seen), 32'(bd_exp));
        check("busy at end", 32'(busy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
